// File: rtl/alt_cal_dprio_pkg.sv
// Shared types and widths for the DPRIO responder.
// Imported by the responder top and its register file.
package alt_cal_dprio_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int QUAD_W = 9;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_BUSY = 2'd1,
    ST_RD_BUSY = 2'd2
  } dprio_state_e;

endpackage

// File: rtl/alt_cal_dprio_regfile.sv
// Register file behind the DPRIO responder.
// One write port, one read port, testbus bit-0 taps.
module alt_cal_dprio_regfile
  import alt_cal_dprio_pkg::*;
#(
  parameter int ADDR_BITS = 5,
  parameter int NCH       = 1,
  parameter int TB_BASE   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [DATA_W-1:0]    wdata_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [DATA_W-1:0]    rdata_o,
  output logic [NCH-1:0]       tap_o
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage: cleared on reset, one word written per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

  // Channels whose register lies past the file read as 0.
  for (genvar g = 0; g < NCH; g++) begin : g_tap
    localparam int IDX = TB_BASE + g;
    if (IDX < DEPTH) begin : g_in
      assign tap_o[g] = mem_q[IDX][0];
    end else begin : g_out
      assign tap_o[g] = 1'b0;
    end
  end

endmodule

// File: rtl/alt_cal_dprio_responder.sv
// Simulation DPRIO target for the calibration controller.
// Single-word reads/writes with programmable busy latency.
module alt_cal_dprio_responder
  import alt_cal_dprio_pkg::*;
#(
  parameter int number_of_channels = 1,
  parameter int ADDR_BITS          = 5,
  parameter int QUAD_ID            = 0,
  parameter int WR_LATENCY         = 3,
  parameter int RD_LATENCY         = 4,
  parameter int TESTBUS_BASE       = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [ADDR_W-1:0]             dprio_addr,
  input  logic [DATA_W-1:0]             dprio_dataout,
  input  logic                          dprio_rden,
  input  logic                          dprio_wren,
  input  logic [QUAD_W-1:0]             quad_addr,
  output logic                          dprio_busy,
  output logic [DATA_W-1:0]             dprio_datain,
  output logic [number_of_channels-1:0] testbuses,
  output logic                          proto_err,
  output logic                          addr_err
);

  localparam logic [QUAD_W-1:0] QUAD    = QUAD_W'(QUAD_ID);
  localparam logic [CNT_W-1:0]  WR_LOAD = CNT_W'(WR_LATENCY - 1);
  localparam logic [CNT_W-1:0]  RD_LOAD = CNT_W'(RD_LATENCY - 1);

  dprio_state_e state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [QUAD_W-1:0] quad_q, quad_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              perr_q, perr_d;
  logic              aerr_q, aerr_d;
  logic [number_of_channels-1:0] tb_q, tap;
  logic [DATA_W-1:0] rdata;
  logic              req, idle, in_rng, hit, commit;

  assign req    = dprio_rden | dprio_wren;
  assign idle   = state_q == ST_IDLE;
  assign in_rng = (addr_q >> ADDR_BITS) == '0;
  assign hit    = (quad_q == QUAD) && in_rng;
  assign commit = (state_q == ST_WR_BUSY) && (cnt_q == '0) && hit;

  // Accept in IDLE, count down busy, finish on zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    quad_d  = quad_q;
    dout_d  = dout_q;
    perr_d  = perr_q;
    aerr_d  = aerr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = dprio_addr;
          data_d  = dprio_dataout;
          quad_d  = quad_addr;
          state_d = dprio_wren ? ST_WR_BUSY : ST_RD_BUSY;
          cnt_d   = dprio_wren ? WR_LOAD : RD_LOAD;
          if (dprio_wren && dprio_rden) perr_d = 1'b1;
          if (quad_addr == QUAD &&
              (dprio_addr >> ADDR_BITS) != '0)
            aerr_d = 1'b1;
        end
      end
      default: begin
        if (req) perr_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          if (state_q == ST_RD_BUSY)
            dout_d = hit ? rdata : '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  // Control and status state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      quad_q  <= '0;
      dout_q  <= '0;
      perr_q  <= 1'b0;
      aerr_q  <= 1'b0;
      tb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      quad_q  <= quad_d;
      dout_q  <= dout_d;
      perr_q  <= perr_d;
      aerr_q  <= aerr_d;
      tb_q    <= tap;
    end
  end

  alt_cal_dprio_regfile #(
    .ADDR_BITS (ADDR_BITS),
    .NCH       (number_of_channels),
    .TB_BASE   (TESTBUS_BASE)
  ) u_regfile (
    .clk     (clock),
    .rst_n   (reset_n),
    .we_i    (commit),
    .waddr_i (addr_q[ADDR_BITS-1:0]),
    .wdata_i (data_q),
    .raddr_i (addr_q[ADDR_BITS-1:0]),
    .rdata_o (rdata),
    .tap_o   (tap)
  );

  assign dprio_busy   = !idle;
  assign dprio_datain = dout_q;
  assign testbuses    = tb_q;
  assign proto_err    = perr_q;
  assign addr_err     = aerr_q;

endmodule

// File: tb/tb_alt_cal_dprio_responder.sv
// Scoreboard bench for the DPRIO responder.
// Stimulus pushes expected busy length / read data; monitor checks on busy fall.
module tb_alt_cal_dprio_responder;

  typedef struct {
    string       name;
    int          len;
    bit          is_rd;
    logic [15:0] data;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] dprio_addr = '0;
  logic [15:0] dprio_dataout = '0;
  logic        dprio_rden = 1'b0;
  logic        dprio_wren = 1'b0;
  logic [8:0]  quad_addr = '0;
  logic        dprio_busy;
  logic [15:0] dprio_datain;
  logic [0:0]  testbuses;
  logic        proto_err;
  logic        addr_err;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   run = 0;

  alt_cal_dprio_responder dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .dprio_addr    (dprio_addr),
    .dprio_dataout (dprio_dataout),
    .dprio_rden    (dprio_rden),
    .dprio_wren    (dprio_wren),
    .quad_addr     (quad_addr),
    .dprio_busy    (dprio_busy),
    .dprio_datain  (dprio_datain),
    .testbuses     (testbuses),
    .proto_err     (proto_err),
    .addr_err      (addr_err)
  );

  always #5 clock = ~clock;

  task automatic chk(string n, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Monitor: measure busy width, compare on falling edge of busy.
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      run = 0;
    end else if (dprio_busy === 1'b1) begin
      run++;
    end else if (run != 0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_txn: got busy %0d cycles expected none", run);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "_len"}, 16'(run), 16'(e.len));
        if (e.is_rd) chk({e.name, "_data"}, dprio_datain, e.data);
      end
      run = 0;
    end
  end

  task automatic start(bit wr, bit rd, logic [15:0] a, logic [15:0] d,
                       logic [8:0] q);
    @(posedge clock); #1;
    dprio_wren = wr; dprio_rden = rd;
    dprio_addr = a; dprio_dataout = d; quad_addr = q;
    @(posedge clock); #1;
    dprio_wren = 1'b0; dprio_rden = 1'b0;
  endtask

  task automatic wait_done(string n);
    int i;
    i = 0;
    while (dprio_busy === 1'b1 && i < 40) begin
      @(posedge clock); #1;
      i++;
    end
    if (dprio_busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy %b expected 0", n, dprio_busy);
    end
    @(posedge clock); #1;
  endtask

  task automatic wr(string n, logic [15:0] a, logic [15:0] d,
                    logic [8:0] q);
    exp_q.push_back('{name: n, len: 3, is_rd: 1'b0, data: 16'h0});
    start(1'b1, 1'b0, a, d, q);
    wait_done(n);
  endtask

  task automatic rd(string n, logic [15:0] a, logic [8:0] q,
                    logic [15:0] expd);
    exp_q.push_back('{name: n, len: 4, is_rd: 1'b1, data: expd});
    start(1'b0, 1'b1, a, 16'h0, q);
    wait_done(n);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock); #1;
    chk("rst_busy", 16'(dprio_busy), 16'h0);
    chk("rst_datain", dprio_datain, 16'h0);
    chk("rst_testbus", 16'(testbuses), 16'h0);
    chk("rst_proto", 16'(proto_err), 16'h0);
    chk("rst_addr", 16'(addr_err), 16'h0);

    wr("wr_a5c3", 16'd3, 16'hA5C3, 9'h000);
    rd("rd_a5c3", 16'd3, 9'h000, 16'hA5C3);

    wr("wr_tb1", 16'd16, 16'h0001, 9'h000);
    chk("testbus_1", 16'(testbuses), 16'h1);
    wr("wr_tb0", 16'd16, 16'h0000, 9'h000);
    chk("testbus_0", 16'(testbuses), 16'h0);

    wr("wr_qmiss", 16'd3, 16'hBEEF, 9'h1FF);
    rd("rd_after_qmiss", 16'd3, 9'h000, 16'hA5C3);
    rd("rd_qmiss", 16'd3, 9'h1FF, 16'h0000);
    chk("qmiss_proto", 16'(proto_err), 16'h0);
    chk("qmiss_addr", 16'(addr_err), 16'h0);

    exp_q.push_back('{name: "wr_both", len: 3, is_rd: 1'b0, data: 16'h0});
    start(1'b1, 1'b1, 16'd5, 16'h1234, 9'h000);
    wait_done("wr_both");
    chk("both_proto", 16'(proto_err), 16'h1);
    rd("rd_both", 16'd5, 9'h000, 16'h1234);
    wr("wr_hold", 16'd6, 16'h7777, 9'h000);
    chk("datain_hold", dprio_datain, 16'h1234);

    start(1'b1, 1'b0, 16'd7, 16'hFFFF, 9'h000);
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", 16'(dprio_busy), 16'h0);
    @(negedge clock); #2;
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("rst_mid_proto", 16'(proto_err), 16'h0);
    rd("rd_after_rst", 16'd7, 9'h000, 16'h0000);

    wr("wr_5a5a", 16'd9, 16'h5A5A, 9'h000);
    exp_q.push_back('{name: "rd_pulse", len: 4, is_rd: 1'b1, data: 16'h5A5A});
    start(1'b0, 1'b1, 16'd9, 16'h0, 9'h000);
    @(posedge clock); #1;
    dprio_rden = 1'b1;
    @(posedge clock); #1;
    dprio_rden = 1'b0;
    wait_done("rd_pulse");
    chk("pulse_proto", 16'(proto_err), 16'h1);

    chk("pre_oor_addr", 16'(addr_err), 16'h0);
    rd("rd_oor", 16'd40, 9'h000, 16'h0000);
    chk("oor_addr", 16'(addr_err), 16'h1);

    repeat (2) @(posedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_txn: got %0d expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
